// File: rtl/turbo_deinterleaver_if.sv
// Bit-serial handshake bundle between a block source/sink and the QPP de-interleaver.
interface turbo_deinterleaver_if;
  logic data_in;
  logic in_start;
  logic in_blocksize;
  logic in_end;
  logic in_ready;
  logic data_out;
  logic out_valid;
  logic out_start;
  logic out_end;
  logic out_blocksize;
  logic err;

  modport master (
    output data_in, in_start, in_blocksize, in_end,
    input  in_ready, data_out, out_valid, out_start, out_end, out_blocksize, err
  );

  modport slave (
    input  data_in, in_start, in_blocksize, in_end,
    output in_ready, data_out, out_valid, out_start, out_end, out_blocksize, err
  );
endinterface

// File: rtl/turbo_deinterleaver.sv
// LTE QPP turbo de-interleaver: ping-pong 6144x1 banks, input scattered to pi(k),
// output read back in natural order.
module turbo_deinterleaver (
  input  logic                  clk,
  input  logic                  reset,
  turbo_deinterleaver_if.slave  bus
);

  localparam int unsigned AW    = 13;
  localparam int unsigned DEPTH = 6144;

  localparam logic [AW-1:0] K_S      = 13'd1056;
  localparam logic [AW-1:0] F1_S     = 13'd17;
  localparam logic [AW-1:0] F2_S     = 13'd66;
  localparam logic [AW-1:0] TWO_F2_S = 13'd132;
  localparam logic [AW-1:0] K_L      = 13'd6144;
  localparam logic [AW-1:0] F1_L     = 13'd263;
  localparam logic [AW-1:0] F2_L     = 13'd480;
  localparam logic [AW-1:0] TWO_F2_L = 13'd960;

  typedef enum logic {W_IDLE, W_FILL} w_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_e;

  w_state_e        w_state_q, w_state_d;
  r_state_e        r_state_q, r_state_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [1:0]      full_q, full_d;
  logic [1:0]      bs_q, bs_d;
  logic            wbs_q, wbs_d;
  logic [AW-1:0]   k_q, k_d;
  logic [AW-1:0]   pi_q, pi_d;
  logic [AW-1:0]   g_q, g_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic            out_start_q, out_start_d;
  logic            out_end_q, out_end_d;
  logic            out_bs_q, out_bs_d;
  logic            rd_bit_q;

  logic            mem_q [2][DEPTH];

  logic            in_ready_c;
  logic            we_c;
  logic [AW-1:0]   waddr_c;
  logic            set_full_c;
  logic            re_c;
  logic [AW-1:0]   rd_addr_c;
  logic            clr_full_c;
  logic [AW-1:0]   kw_c;
  logic [AW-1:0]   kr_c;
  logic [AW-1:0]   g0_c;

  // (a + b) mod m for a, b < m using one conditional subtract
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic [AW-1:0] m);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[AW-1:0];
  endfunction

  // Write side: accept a block, step the QPP recursion, validate framing
  always_comb begin
    w_state_d  = w_state_q;
    wr_bank_d  = wr_bank_q;
    k_d        = k_q;
    pi_d       = pi_q;
    g_d        = g_q;
    wbs_d      = wbs_q;
    bs_d       = bs_q;
    set_full_c = 1'b0;
    err_d      = 1'b0;
    we_c       = 1'b0;
    waddr_c    = pi_q;
    g0_c       = '0;
    kw_c       = wbs_q ? K_L : K_S;
    in_ready_c = (w_state_q == W_IDLE) && !full_q[wr_bank_q];
    unique case (w_state_q)
      W_IDLE: begin
        if (bus.in_start) begin
          if (in_ready_c) begin
            we_c             = 1'b1;
            waddr_c          = '0;
            k_d              = 13'd1;
            wbs_d            = bus.in_blocksize;
            bs_d[wr_bank_q]  = bus.in_blocksize;
            g0_c             = bus.in_blocksize ? mod_add(F1_L, F2_L, K_L)
                                                : mod_add(F1_S, F2_S, K_S);
            pi_d             = g0_c;
            g_d              = bus.in_blocksize ? mod_add(g0_c, TWO_F2_L, K_L)
                                                : mod_add(g0_c, TWO_F2_S, K_S);
            w_state_d        = W_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (bus.in_start || (bus.in_end != (k_q == kw_c - 13'd1))) begin
          err_d     = 1'b1;
          w_state_d = W_IDLE;
        end else begin
          we_c = 1'b1;
          if (bus.in_end) begin
            set_full_c = 1'b1;
            wr_bank_d  = ~wr_bank_q;
            w_state_d  = W_IDLE;
          end else begin
            k_d  = k_q + 13'd1;
            pi_d = mod_add(pi_q, g_q, kw_c);
            g_d  = mod_add(g_q, wbs_q ? TWO_F2_L : TWO_F2_S, kw_c);
          end
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read side: sweep addresses 0..K-1 of the full bank, address 0 issued from idle
  always_comb begin
    r_state_d   = r_state_q;
    rd_bank_d   = rd_bank_q;
    raddr_d     = raddr_q;
    re_c        = 1'b0;
    rd_addr_c   = raddr_q;
    clr_full_c  = 1'b0;
    kr_c        = bs_q[rd_bank_q] ? K_L : K_S;
    unique case (r_state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          re_c      = 1'b1;
          rd_addr_c = '0;
          raddr_d   = 13'd1;
          r_state_d = R_DRAIN;
        end
      end
      R_DRAIN: begin
        re_c = 1'b1;
        if (raddr_q == kr_c - 13'd1) begin
          clr_full_c = 1'b1;
          rd_bank_d  = ~rd_bank_q;
          r_state_d  = R_IDLE;
        end else begin
          raddr_d = raddr_q + 13'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    out_valid_d = re_c;
    out_start_d = re_c && (rd_addr_c == '0);
    out_end_d   = re_c && (rd_addr_c == kr_c - 13'd1);
    out_bs_d    = re_c && bs_q[rd_bank_q];
  end

  // Full flags: fill completion and drain completion may land in the same cycle
  always_comb begin
    full_d = full_q;
    if (clr_full_c) full_d[rd_bank_q] = 1'b0;
    if (set_full_c) full_d[wr_bank_q] = 1'b1;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      bs_q        <= '0;
      wbs_q       <= 1'b0;
      k_q         <= '0;
      pi_q        <= '0;
      g_q         <= '0;
      raddr_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_end_q   <= 1'b0;
      out_bs_q    <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      bs_q        <= bs_d;
      wbs_q       <= wbs_d;
      k_q         <= k_d;
      pi_q        <= pi_d;
      g_q         <= g_d;
      raddr_q     <= raddr_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_end_q   <= out_end_d;
      out_bs_q    <= out_bs_d;
    end
  end

  // Bank storage: scattered write, synchronous natural-order read
  always_ff @(posedge clk) begin
    if (we_c && !reset) mem_q[wr_bank_q][waddr_c] <= bus.data_in;
    rd_bit_q <= mem_q[rd_bank_q][rd_addr_c];
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.data_out      = rd_bit_q & out_valid_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_start     = out_start_q;
  assign bus.out_end       = out_end_q;
  assign bus.out_blocksize = out_bs_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// Randomized bench for turbo_deinterleaver against a direct QPP formula model.
module tb_turbo_deinterleaver;

  logic clk = 1'b0;
  logic reset;
  turbo_deinterleaver_if ifc();

  turbo_deinterleaver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit blk_bits [6144];
  bit exp_q [$];
  int exp_len_q [$];
  int exp_bs_q [$];
  bit mon_en = 1'b0;
  int blocks_out = 0;
  int err_cnt = 0;
  int t_end = 0;
  int t_start = 0;
  int last_wait = 0;

  bit in_blk = 1'b0;
  int pos, bad, bs_bad, ones, one_pos, cur_bs, elen, ebs;
  int last_ones, last_one_pos, last_end_pos;
  int err0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: output position pi(k) carries input bit k
  function automatic void model_push(input bit bs);
    longint kk, f1, f2, p;
    bit nat [6144];
    kk = bs ? 6144 : 1056;
    f1 = bs ? 263 : 17;
    f2 = bs ? 480 : 66;
    for (longint k = 0; k < kk; k++) begin
      p = (f1 * k + f2 * k * k) % kk;
      nat[p] = blk_bits[k];
    end
    for (int n = 0; n < int'(kk); n++) exp_q.push_back(nat[n]);
    exp_len_q.push_back(int'(kk));
    exp_bs_q.push_back(int'(bs));
  endfunction

  task automatic fill_rand();
    for (int k = 0; k < 6144; k++) blk_bits[k] = 1'($urandom);
  endtask

  task automatic fill_zero();
    for (int k = 0; k < 6144; k++) blk_bits[k] = 1'b0;
  endtask

  // Called just after a posedge (+#1); waits for in_ready then streams the block
  task automatic send_block(input bit bs, input int end_at, input bit push);
    int kk;
    int w;
    kk = bs ? 6144 : 1056;
    w = 0;
    while (!ifc.in_ready && w < 20000) begin
      @(posedge clk); #1;
      w++;
    end
    last_wait = w;
    check_eq("in_ready_wait", int'(ifc.in_ready), 1);
    if (push) model_push(bs);
    for (int k = 0; k < kk; k++) begin
      ifc.data_in      = blk_bits[k];
      ifc.in_start     = (k == 0);
      ifc.in_blocksize = (k == 0) ? bs : 1'($urandom);
      ifc.in_end       = (k == end_at);
      if (k == end_at) t_end = cyc;
      @(posedge clk); #1;
      if (k == end_at) break;
    end
    ifc.data_in      = 1'b0;
    ifc.in_start     = 1'b0;
    ifc.in_end       = 1'b0;
    ifc.in_blocksize = 1'b0;
  endtask

  task automatic wait_blocks(input int n);
    int w;
    w = 0;
    while (blocks_out < n && w < 20000) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("blocks_done", blocks_out, n);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: assembles blocks and scores them against the model queue
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      in_blk = 1'b0;
    end else begin
      if (ifc.err) err_cnt++;
      if (ifc.out_valid) begin
        if (ifc.out_start) begin
          check_eq("start_in_block", int'(in_blk), 0);
          in_blk = 1'b1;
          pos = 0; bad = 0; bs_bad = 0; ones = 0; one_pos = -1;
          cur_bs = int'(ifc.out_blocksize);
          t_start = cyc;
        end
        if (!in_blk) begin
          check_eq("stray_valid", int'(in_blk), 1);
        end else begin
          if (exp_q.size() == 0) bad++;
          else if (ifc.data_out != exp_q.pop_front()) bad++;
          if (int'(ifc.out_blocksize) != cur_bs) bs_bad++;
          if (ifc.data_out) begin
            ones++;
            one_pos = pos;
          end
          if (ifc.out_end) begin
            elen = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : -1;
            ebs  = (exp_bs_q.size() > 0) ? exp_bs_q.pop_front() : -1;
            check_eq("blk_len", pos + 1, elen);
            check_eq("blk_bits", bad, 0);
            check_eq("blk_bs", cur_bs, ebs);
            check_eq("blk_bs_hold", bs_bad, 0);
            last_ones = ones;
            last_one_pos = one_pos;
            last_end_pos = pos;
            blocks_out++;
            in_blk = 1'b0;
          end
          pos++;
        end
      end else if (in_blk) begin
        check_eq("contiguous", int'(ifc.out_valid), 1);
        in_blk = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.data_in = 1'b0; ifc.in_start = 1'b0; ifc.in_blocksize = 1'b0; ifc.in_end = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outs", int'({ifc.out_valid, ifc.out_start, ifc.out_end, ifc.err,
                               ifc.data_out, ifc.out_blocksize}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_in_ready", int'(ifc.in_ready), 1);
    mon_en = 1'b1;

    // One-hot K=1056 blocks
    fill_zero(); blk_bits[1] = 1'b1;
    send_block(1'b0, 1055, 1'b1);
    wait_blocks(1);
    check_eq("k1_ones", last_ones, 1);
    check_eq("k1_pos", last_one_pos, 83);
    fill_zero(); blk_bits[2] = 1'b1;
    send_block(1'b0, 1055, 1'b1);
    wait_blocks(2);
    check_eq("k2_pos", last_one_pos, 298);

    // One-hot K=6144 block
    fill_zero(); blk_bits[1] = 1'b1;
    send_block(1'b1, 6143, 1'b1);
    wait_blocks(3);
    check_eq("l1_pos", last_one_pos, 743);
    check_eq("l_end_pos", last_end_pos, 6143);

    // Random K=1056 with idle read side: latency from in_end to out_start
    fill_rand();
    send_block(1'b0, 1055, 1'b1);
    wait_blocks(4);
    check_eq("latency", t_start - t_end, 2);

    // Back-to-back 1056, 6144, 1056, then a fourth that must wait for a bank
    err0 = err_cnt;
    fill_rand(); send_block(1'b0, 1055, 1'b1);
    fill_rand(); send_block(1'b1, 6143, 1'b1);
    fill_rand(); send_block(1'b0, 1055, 1'b1);
    check_eq("rdy_both_full", int'(ifc.in_ready), 0);
    ifc.in_start = 1'b1;
    @(posedge clk); #1;
    ifc.in_start = 1'b0;
    fill_rand(); send_block(1'b0, 1055, 1'b1);
    check_eq("b2b_waited", int'(last_wait > 1000), 1);
    wait_blocks(8);
    check_eq("b2b_err", err_cnt - err0, 1);

    // Early in_end aborts the block; next block reuses the bank
    err0 = err_cnt;
    fill_rand(); send_block(1'b0, 500, 1'b0);
    fill_rand(); send_block(1'b0, 1055, 1'b1);
    wait_blocks(9);
    check_eq("early_end_err", err_cnt - err0, 1);

    // Missing in_end at K-1 aborts the block
    err0 = err_cnt;
    fill_rand(); send_block(1'b0, -1, 1'b0);
    fill_rand(); send_block(1'b1, 6143, 1'b1);
    wait_blocks(10);
    check_eq("no_end_err", err_cnt - err0, 1);

    // Reset mid-drain and mid-fill
    mon_en = 1'b0;
    fill_rand(); send_block(1'b0, 1055, 1'b0);
    ifc.in_start = 1'b1;
    ifc.in_blocksize = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ifc.data_in = 1'($urandom);
      @(posedge clk); #1;
      ifc.in_start = 1'b0;
    end
    ifc.data_in = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_outs", int'({ifc.out_valid, ifc.out_start, ifc.out_end, ifc.err,
                                   ifc.data_out, ifc.out_blocksize}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_in_ready", int'(ifc.in_ready), 1);
    mon_en = 1'b1;
    repeat (300) begin
      @(posedge clk); #1;
    end
    check_eq("no_partial_out", blocks_out, 10);
    fill_rand(); send_block(1'b0, 1055, 1'b1);
    wait_blocks(11);
    check_eq("exp_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/turbo_deinterleaver.md
TURBO_DEINTERLEAVER -- requirements
Module: turbo_deinterleaver

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 Port list, clock and reset first:
  clk  in  1  rising-edge clock for all state.
  reset  in  1  synchronous active-high reset.
  data_in  in  1  interleaved bit, valid every cycle of an accepted block.
  in_start  in  1  one-cycle pulse coincident with input bit 0.
  in_blocksize  in  1  sampled with in_start: 0 = K 1056, 1 = K 6144.
  in_end  in  1  one-cycle pulse coincident with input bit K-1.
  in_ready  out  1  high when in_start will be accepted this cycle.
  data_out  out  1  de-interleaved bit in natural order.
  out_valid  out  1  data_out valid.
  out_start  out  1  high with output bit 0.
  out_end  out  1  high with output bit K-1.
  out_blocksize  out  1  block size of the block being output.
  err  out  1  one-cycle pulse on protocol violation.

Function
REQ-003 SHALL hold two 6144x1 banks (ping-pong); write side and read side alternate banks, starting with bank 0 after reset.
REQ-004 QPP parameters SHALL be K 1056: f1 17, f2 66; K 6144: f1 263, f2 480.
REQ-005 Write address SHALL be pi(k) = (f1*k + f2*k^2) mod K, generated recursively with no multiplier: pi(0) 0, g(0) = (f1+f2) mod K, pi(k+1) = (pi(k)+g(k)) mod K, g(k+1) = (g(k)+2*f2) mod K; all values 13 bits, each mod done by a single conditional subtract of K.
REQ-006 Input bit k SHALL be written to address pi(k) of the write bank; the read side SHALL read addresses 0..K-1 in order.
REQ-007 Write FSM SHALL have states W_IDLE and W_FILL. W_IDLE -> W_FILL on in_start while in_ready; W_FILL -> W_IDLE on in_end at k = K-1 (bank marked full) or on any error.
REQ-008 in_ready SHALL equal (write FSM in W_IDLE) AND (target write bank not full).
REQ-009 In W_FILL, in_end at k != K-1, missing in_end at k = K-1, or in_start SHALL each pulse err, discard the block (bank stays empty) and return to W_IDLE; the write bank does not toggle.
REQ-010 in_start while in_ready is low SHALL pulse err and be ignored.
REQ-011 Read FSM SHALL have states R_IDLE and R_DRAIN. R_IDLE -> R_DRAIN when the read bank is full; on the last address it clears that bank's full flag, toggles the read bank and returns to R_IDLE.
REQ-012 Bank read SHALL be synchronous with 1-cycle latency: in_end at cycle T, with the read side idle, SHALL give out_valid and out_start with bit 0 at T+2, then K contiguous valid cycles with out_end on the last.
REQ-013 out_blocksize SHALL be stored per bank at in_start and held constant while out_valid is high.
REQ-014 When a block finishes writing in the same cycle another block finishes draining, both SHALL take effect; no bit is lost or duplicated.
REQ-015 With both banks full, in_ready SHALL stay low until the drain in progress frees a bank; earliest acceptance is the cycle after that bank's full flag clears.
REQ-016 The next in_start SHALL be accepted no earlier than the cycle after in_end.

Reset
REQ-017 Reset SHALL force W_IDLE, R_IDLE, both full flags 0, write/read bank pointers to 0, and counters to 0; it aborts any block in progress.
REQ-018 During and after reset, out_valid, out_start, out_end, err, data_out and out_blocksize SHALL be 0; in_ready is 1 the cycle after reset deasserts. Bank contents are not reset.

Verification
REQ-019 K 1056 block, only input bit k=1 set -> output block has a single 1 at position 83 (pi(1)=83); bit k=2 alone -> position 298.
REQ-020 K 6144 block, only input bit k=1 set -> single 1 at output position 743; out_blocksize 1; out_end at position 6143.
REQ-021 Random K 1056 block, in_end at T -> out_start at T+2; output equals software QPP de-interleave; 1056 contiguous out_valid cycles.
REQ-022 Three back-to-back blocks (1056, 6144, 1056) presented as soon as in_ready allows -> in_ready low while both banks are full; all three blocks output in order and bit-exact; err never pulses.
REQ-023 in_end at k=500 of a K 1056 block -> err pulse, no output block, next valid block goes to the same bank and outputs correctly.
REQ-024 reset asserted mid-drain and mid-fill -> outputs 0 the next cycle, in_ready 1 after reset, partial blocks never output.
